// File: rtl/lsu_ctrl.sv
// Load/store controller: big-endian sub-word extraction/extension and read-modify-write
// stores over a word-wide, 1-cycle-latency data memory. Optional macro: LSU_ALIGN_CHECK_EN.
module lsu_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] mem_addr,
    output logic        mem_wr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [2:0] {IDLE, RD, LD, MRG, WR} state_t;

    state_t      state, state_nxt;
    logic [31:0] addr_q;
    logic [1:0]  size_q;
    logic        we_q;
    logic        uns_q;
    logic [15:0] wdata_q;
    logic        accept;
    logic        mis;
    logic [7:0]  bsel;
    logic [15:0] hsel;
    logic [31:0] ld_data;
    logic [31:0] merged;

    assign accept    = req_valid && req_ready;
    assign req_ready = (state == IDLE);
    assign mem_wr    = (state == WR);
    assign mem_addr  = {addr_q[31:2], 2'b00};

`ifdef LSU_ALIGN_CHECK_EN
    assign mis = ((req_size == 2'b01) && req_addr[0]) ||
                 (req_size[1] && (req_addr[1:0] != 2'b00));
`else
    assign mis = 1'b0;
`endif

    // Lane select and merge share one decode; size 11 falls through to word.
    always_comb begin
        bsel    = '0;
        hsel    = '0;
        merged  = mem_rdata;
        ld_data = mem_rdata;
        if (size_q == 2'b00) begin
            case (addr_q[1:0])
                2'd0: begin bsel = mem_rdata[31:24]; merged[31:24] = wdata_q[7:0]; end
                2'd1: begin bsel = mem_rdata[23:16]; merged[23:16] = wdata_q[7:0]; end
                2'd2: begin bsel = mem_rdata[15:8];  merged[15:8]  = wdata_q[7:0]; end
                default: begin bsel = mem_rdata[7:0]; merged[7:0] = wdata_q[7:0]; end
            endcase
            ld_data = {{24{~uns_q & bsel[7]}}, bsel};
        end else if (size_q == 2'b01) begin
            if (addr_q[1]) begin
                hsel         = mem_rdata[15:0];
                merged[15:0] = wdata_q;
            end else begin
                hsel          = mem_rdata[31:16];
                merged[31:16] = wdata_q;
            end
            ld_data = {{16{~uns_q & hsel[15]}}, hsel};
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept && !mis) state_nxt = (req_we && req_size[1]) ? WR : RD;
            RD:   state_nxt = we_q ? MRG : LD;
            LD:   state_nxt = IDLE;
            MRG:  state_nxt = WR;
            WR:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q    <= '0;
            size_q    <= '0;
            we_q      <= 1'b0;
            uns_q     <= 1'b0;
            wdata_q   <= '0;
            mem_wdata <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= 1'b0;
            if (accept) begin
                addr_q  <= req_addr;
                size_q  <= req_size;
                we_q    <= req_we;
                uns_q   <= req_unsigned;
                wdata_q <= req_wdata[15:0];
                if (mis) begin
                    rsp_valid <= 1'b1;
                    rsp_rdata <= '0;
                end else if (req_we && req_size[1]) begin
                    mem_wdata <= req_wdata;
                end
            end
            case (state)
                LD: begin
                    rsp_valid <= 1'b1;
                    rsp_rdata <= ld_data;
                end
                MRG: mem_wdata <= merged;
                WR: begin
                    rsp_valid <= 1'b1;
                    rsp_rdata <= '0;
                end
                default: ;
            endcase
        end
    end

`ifdef LSU_ALIGN_CHECK_EN
    logic err_q;
    // Error flag only changes when a response is produced, so it holds between pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                          err_q <= 1'b0;
        else if (accept && mis)            err_q <= 1'b1;
        else if (state == LD || state == WR) err_q <= 1'b0;
    end
    assign rsp_err = err_q;
`else
    assign rsp_err = 1'b0;
`endif

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store controller sitting between the single-cycle datapath's memory stage and the word-wide data memory. Accepts byte, halfword and word load/store requests from the core, and issues word-aligned reads and writes to the memory. Performs big-endian lane extraction with sign or zero extension, and read-modify-write for sub-word stores. Flags misaligned accesses and reports completion with a one-cycle response pulse.

## Interface
Parameters:
- None.

Ports:
- clk  in  1  rising-edge clock, shared with data memory
- rst  in  1  asynchronous reset, active-low
- req_valid  in  1  request present
- req_ready  out  1  controller can accept; high only in IDLE
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 treated as word
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified for byte/half
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  32  extended load data; 0 for stores and errors
- rsp_err  out  1  misaligned request; qualified by rsp_valid
- mem_addr  out  32  word-aligned address, {addr_q[31:2],2'b00}
- mem_wr  out  1  memory write strobe; 0 = read
- mem_wdata  out  32  full word to write
- mem_rdata  in  32  memory read data, registered by memory (1-cycle latency)

## Operation
- Request fields are captured into addr_q, size_q, we_q, uns_q and wdata_q at the accept edge (req_valid && req_ready).
- Byte order is big-endian: offset 0 maps to bits [31:24] and offset 3 to bits [7:0]. A halfword at offset 0 maps to [31:16]; at offset 2 it maps to [15:0].
- States:
  - IDLE: no request in flight.
  - RD: drive mem_addr with mem_wr=0 so the memory captures the word.
  - LD: mem_rdata is valid; extract and extend the lane, then register it into rsp_rdata.
  - MRG: mem_rdata is valid; replace the target lane with the low bits of wdata_q and register the merged word.
  - WR: mem_wr=1; mem_wdata = merged or full word.
- Transitions:
  - Load: IDLE→RD→LD→IDLE.
  - Word store: IDLE→WR→IDLE.
  - Byte/half store: IDLE→RD→MRG→WR→IDLE.
- Misaligned request: a half with addr[0]=1, or a word with addr[1:0]≠0.
  - Accepted, then no memory access is made and the FSM stays in IDLE.
  - rsp_valid=1 and rsp_err=1 are registered at the accept edge; rsp_rdata=0.
- mem_wr is decoded from state (state==WR). mem_addr and mem_wdata come from registers, so there are no glitches on memory inputs.
- Reset values: state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, mem_wr=0, mem_addr=0, mem_wdata=0.
- Reset mid-operation:
  - The FSM returns to IDLE immediately and mem_wr drops asynchronously.
  - Any RMW that has not reached WR leaves memory unmodified.
  - A pending response is dropped.

## Timing
- Edge 0 is the accept edge.
- Word load: RD between edges 0–1, LD between edges 1–2. rsp_valid is high from edge 2 to edge 3.
- Word store: WR between edges 0–1, memory write at edge 1. rsp_valid is high from edge 1 to edge 2.
- Sub-word store:
  - RD between edges 0–1, MRG between edges 1–2; the merged word is registered at edge 2.
  - WR between edges 2–3, memory write at edge 3.
  - rsp_valid is high from edge 3 to edge 4.
- Misaligned request: rsp_valid is high from edge 0 to edge 1.
- The FSM re-enters IDLE on the same edge rsp_valid rises. req_ready is therefore high during the response cycle, and a back-to-back request accepted then has no bubble.
- rsp_valid is never high for two consecutive cycles from one request. rsp_rdata and rsp_err hold their last values while rsp_valid=0.

## Configuration
- LSU_ALIGN_CHECK_EN defined: misalignment detection and error response operate as described above.
- LSU_ALIGN_CHECK_EN undefined:
  - No misalignment check; rsp_err is tied to 0.
  - Halfword lane selection uses addr[1] only, and word accesses ignore addr[1:0].
  - Every request follows the normal state path.

## Test plan
- Word at 0x10 = 0x11223344; store byte to 0x12 with wdata 0x000000AA → word at 0x10 = 0x1122AA44, rsp_valid at edge 3, mem_wr high exactly one cycle.
- Word at 0x20 = 0x112233F4; load byte signed from 0x23 → rsp_rdata 0xFFFFFFF4 at edge 2; load byte unsigned from 0x23 → 0x000000F4.
- Word at 0x30 = 0x8001_7F00; load half signed from 0x30 → 0xFFFF8001; load half signed from 0x32 → 0x00007F00.
- Store word 0xDEADBEEF to 0x40, then a back-to-back load word from 0x40 accepted in the response cycle → rsp_rdata 0xDEADBEEF, with no idle cycle between the two requests.
- With LSU_ALIGN_CHECK_EN defined: load word from 0x05 → rsp_valid=1, rsp_err=1, rsp_rdata=0 at edge 0, and mem_wr never asserts. Without the macro: the same request reads word 0x04 and rsp_err=0.
- Store byte to 0x50 (initial word 0x01020304), rst driven low during MRG → mem_wr stays 0, state IDLE, all outputs at reset values, word at 0x50 still 0x01020304.
